// File: rtl/led_arb_pkg.sv
// Package: led_arb_pkg
// Shared types and constants for the LED share arbiter.
//   state_t       - arbiter FSM state (IDLE / GRANT / GAP)
//   NUM_REQ       - number of requesters sharing the LED
//   DEF_*         - default prescaler, slot and heartbeat parameters
//   rr_pick()     - round-robin search: first set request at or above ptr, wrapping
//   req_onehot()  - one-hot request mask for an index
package led_arb_pkg;

    localparam int unsigned NUM_REQ        = 4;
    localparam int unsigned IDX_W          = $clog2(NUM_REQ);

    localparam int unsigned DEF_CLK_DIV    = 25_000_000;
    localparam int unsigned DEF_SLOT_TICKS = 4;
    localparam int unsigned DEF_HB_TICKS   = 2;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    // Walk offsets from high to low so the smallest offset from ptr wins.
    function automatic idx_t rr_pick(input logic [NUM_REQ-1:0] req, input idx_t ptr);
        idx_t idx;
        idx_t sel;
        sel = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + IDX_W'(i);
            if (req[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

    function automatic logic [NUM_REQ-1:0] req_onehot(input idx_t idx);
        logic [NUM_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/led_share_arbiter_if.sv
// Interface: led_share_arbiter_if
// Requester-side bundle of the LED share arbiter.
//   iREQ     - per-requester request level
//   iLED_REQ - per-requester desired LED value
//   oGNT     - one-hot or zero grant
//   oLED     - shared LED drive
//   oBUSY    - arbiter is in GRANT or GAP
// Modports: master = requester side, slave = arbiter side.
interface led_share_arbiter_if;

    import led_arb_pkg::*;

    logic [NUM_REQ-1:0] iREQ;
    logic [NUM_REQ-1:0] iLED_REQ;
    logic [NUM_REQ-1:0] oGNT;
    logic               oLED;
    logic               oBUSY;

    modport master (
        output iREQ,
        output iLED_REQ,
        input  oGNT,
        input  oLED,
        input  oBUSY
    );

    modport slave (
        input  iREQ,
        input  iLED_REQ,
        output oGNT,
        output oLED,
        output oBUSY
    );

endinterface

// File: rtl/led_tick_gen.sv
// Module: led_tick_gen
// Prescaler producing a one-cycle tick every CLK_DIV clock cycles.
//   iCLK   - system clock (rising edge)
//   iRST_N - asynchronous active-low reset, clears the count
//   oTICK  - high for the one cycle in which the count equals CLK_DIV-1
module led_tick_gen
    import led_arb_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic iCLK,
    input  logic iRST_N,
    output logic oTICK
);

    localparam int unsigned   CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign oTICK = (cnt == CNT_MAX);

endmodule

// File: rtl/led_share_arbiter.sv
// Module: led_share_arbiter
// Round-robin arbiter sharing one LED among NUM_REQ requesters. An owner keeps the
// LED until it drops its request, or until it has held SLOT_TICKS ticks and another
// requester is waiting. Every hand-over passes through a GAP (LED off) lasting until
// the next tick.
//   iCLK   - system clock (rising edge)
//   iRST_N - asynchronous active-low reset
//   bus    - led_share_arbiter_if.slave: iREQ, iLED_REQ in; oGNT, oLED, oBUSY out
// Optional feature macro: LED_ARB_IDLE_BLINK_EN - heartbeat blink on oLED while IDLE,
// toggling every HB_TICKS ticks, restarted on every entry to IDLE.
module led_share_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned SLOT_TICKS = DEF_SLOT_TICKS,
    parameter int unsigned HB_TICKS   = DEF_HB_TICKS
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    led_share_arbiter_if.slave  bus
);

    if (CLK_DIV < 2 || SLOT_TICKS < 1 || HB_TICKS < 1) begin : g_param_check
        $error("led_share_arbiter: illegal parameter value");
    end

    localparam int unsigned   SW       = $clog2(SLOT_TICKS + 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(SLOT_TICKS);

    logic               tick;
    state_t             state;
    idx_t               owner;
    idx_t               rr_ptr;
    logic [SW-1:0]      slot;
    logic [NUM_REQ-1:0] gnt;
    logic               led;
    logic               busy;

`ifdef LED_ARB_IDLE_BLINK_EN
    localparam int unsigned   HW     = $clog2(HB_TICKS + 1);
    localparam logic [HW-1:0] HB_MAX = HW'(HB_TICKS - 1);
    logic [HW-1:0] hb_cnt;
`endif

    led_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .oTICK  (tick)
    );

    idx_t pick;
    logic owner_release;
    logic preempt;

    always_comb begin
        pick          = rr_pick(bus.iREQ, rr_ptr);
        owner_release = !bus.iREQ[owner];
        preempt       = (slot == SLOT_MAX) && (|(bus.iREQ & ~req_onehot(owner)));
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            slot   <= '0;
            gnt    <= '0;
            led    <= 1'b0;
            busy   <= 1'b0;
`ifdef LED_ARB_IDLE_BLINK_EN
            hb_cnt <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.iREQ) begin
                        owner <= pick;
                        gnt   <= req_onehot(pick);
                        slot  <= '0;
                        led   <= 1'b0;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
`ifdef LED_ARB_IDLE_BLINK_EN
                        if (tick) begin
                            if (hb_cnt == HB_MAX) begin
                                hb_cnt <= '0;
                                led    <= ~led;
                            end else begin
                                hb_cnt <= hb_cnt + 1'b1;
                            end
                        end
`else
                        led <= 1'b0;
`endif
                    end
                end

                GRANT: begin
                    // Release and preemption together still give a single move to GAP.
                    if (owner_release || preempt) begin
                        gnt    <= '0;
                        led    <= 1'b0;
                        rr_ptr <= owner + idx_t'(1);
                        state  <= GAP;
                    end else begin
                        led <= bus.iLED_REQ[owner];
                        if (tick && (slot != SLOT_MAX)) begin
                            slot <= slot + 1'b1;
                        end
                    end
                end

                GAP: begin
                    gnt <= '0;
                    led <= 1'b0;
                    if (tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef LED_ARB_IDLE_BLINK_EN
                        hb_cnt <= '0;
`endif
                    end
                end

                default: begin
                    gnt   <= '0;
                    led   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oGNT  = gnt;
    assign bus.oLED  = led;
    assign bus.oBUSY = busy;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Testbench: tb_led_share_arbiter
// Random and directed stimulus against a behavioural model of the LED share arbiter,
// with CLK_DIV=4, SLOT_TICKS=3, HB_TICKS=2.
module tb_led_share_arbiter;

    localparam int CLK_DIV = 4;
    localparam int SLOT    = 3;
    localparam int HB      = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    led_share_arbiter_if bus ();

    led_share_arbiter #(
        .CLK_DIV    (CLK_DIV),
        .SLOT_TICKS (SLOT),
        .HB_TICKS   (HB)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = none), ticks held, gap flag, time since reset.
    int         m_owner;
    int         m_ptr;
    int         m_held;
    int         m_cyc;
    int         m_hb;
    bit         m_gap;
    logic [3:0] e_gnt;
    logic       e_led;
    logic       e_busy;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_cyc   = 0;
        m_hb    = 0;
        m_gap   = 1'b0;
        e_gnt   = '0;
        e_led   = 1'b0;
        e_busy  = 1'b0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input logic [3:0] req, input logic [3:0] lreq);
        bit tick;
        bit rel;
        bit rivals;
        tick = ((m_cyc % CLK_DIV) == CLK_DIV - 1);
        m_cyc++;
        if (m_gap) begin
            e_gnt = '0;
            e_led = 1'b0;
            if (tick) begin
                m_gap  = 1'b0;
                e_busy = 1'b0;
                m_hb   = 0;
            end
        end else if (m_owner < 0) begin
            if (req != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (req[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        break;
                    end
                end
                m_held = 0;
                e_gnt  = 4'b0001 << m_owner;
                e_led  = 1'b0;
                e_busy = 1'b1;
            end else begin
`ifdef LED_ARB_IDLE_BLINK_EN
                if (tick) begin
                    m_hb++;
                    if (m_hb == HB) begin
                        m_hb  = 0;
                        e_led = ~e_led;
                    end
                end
`else
                e_led = 1'b0;
`endif
            end
        end else begin
            rel    = !req[m_owner];
            rivals = ((req & ~(4'b0001 << m_owner)) != 4'b0000);
            if (rel || (m_held >= SLOT && rivals)) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_gap   = 1'b1;
                e_gnt   = '0;
                e_led   = 1'b0;
            end else begin
                e_led = lreq[m_owner];
                if (tick && m_held < SLOT) m_held++;
            end
        end
    endtask

    // Called at a falling edge: apply inputs, predict, check after the next rising edge.
    task automatic run_cycle(input logic [3:0] req, input logic [3:0] lreq);
        bus.iREQ     = req;
        bus.iLED_REQ = lreq;
        model_step(req, lreq);
        @(negedge clk);
        check_eq("gnt", 32'(bus.oGNT), 32'(e_gnt));
        check_eq("led", 32'(bus.oLED), 32'(e_led));
        check_eq("busy", 32'(bus.oBUSY), 32'(e_busy));
        check_eq("gnt_onehot0", 32'($onehot0(bus.oGNT)), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_gnt"}, 32'(bus.oGNT), 32'd0);
        check_eq({tag, "_led"}, 32'(bus.oLED), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.oBUSY), 32'd0);
    endtask

    logic [3:0] rq;
    bit         reached;

    initial begin
        bus.iREQ     = 4'b1111;
        bus.iLED_REQ = 4'b0000;
        model_reset();

        // Reset held with all requests asserted.
        repeat (3) @(negedge clk);
        check_zero_outputs("in_reset");
        rst_n = 1'b1;

        run_cycle(4'b1111, 4'b1111);
        check_eq("first_gnt", 32'(bus.oGNT), 32'd1);
        repeat (9) run_cycle(4'b1111, 4'(($urandom)));

        // Sole requester keeps the LED well past 20 ticks.
        repeat (120) run_cycle(4'b0001, 4'($urandom));
        check_eq("sole_hold_gnt", 32'(bus.oGNT), 32'd1);

        // Everybody requesting: round-robin rotation with gaps.
        repeat (200) run_cycle(4'b1111, 4'($urandom));

        // Owner 0 drops early while requester 1 waits.
        repeat (20) run_cycle(4'b0000, 4'b0000);
        repeat (6) run_cycle(4'b0011, 4'b0011);
        repeat (30) run_cycle(4'b0010, 4'($urandom));

        // Idle: heartbeat if enabled, dark otherwise.
        repeat (60) run_cycle(4'b0000, 4'($urandom));

        // Random request levels that persist over several cycles.
        rq = 4'b0000;
        repeat (2000) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(15, 0) == 0) rq[b] = ~rq[b];
            end
            run_cycle(rq, 4'($urandom));
        end

        // Reset pulse in the middle of owner 2's grant.
        reached = 1'b0;
        for (int n = 0; n < 64 && !reached; n++) begin
            run_cycle(4'b0100, 4'($urandom));
            if (m_owner == 2 && !m_gap && m_held >= 1) reached = 1'b1;
        end
        check_eq("reach_owner2", 32'(reached), 32'd1);
        check_eq("owner2_gnt", 32'(bus.oGNT), 32'd4);
        #2;
        rst_n    = 1'b0;
        bus.iREQ = 4'b1111;
        #1;
        check_zero_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(4'b1111, 4'b0000);
        check_eq("post_reset_gnt", 32'(bus.oGNT), 32'd1);

        rq = 4'b1111;
        repeat (500) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7, 0) == 0) rq[b] = ~rq[b];
            end
            run_cycle(rq, 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_share_arbiter.md
LED_SHARE_ARBITER -- requirements
Module: led_share_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 25_000_000, clock cycles per tick; legal range >= 2.
REQ-002 Parameter SLOT_TICKS, default 4, minimum ticks an owner keeps the LED before it can be preempted; legal range >= 1.
REQ-003 Parameter HB_TICKS, default 2, ticks per idle-heartbeat half-period; used only under LED_ARB_IDLE_BLINK_EN.
REQ-004 Port iCLK, input, 1 bit: single system clock; all logic rising-edge.
REQ-005 Port iRST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 Port iREQ, input, 4 bits: per-requester request level; held high while the requester wants the LED.
REQ-007 Port iLED_REQ, input, 4 bits: per-requester desired LED value.
REQ-008 Port oGNT, output, 4 bits: one-hot or zero grant.
REQ-009 Port oLED, output, 1 bit: the shared LED drive.
REQ-010 Port oBUSY, output, 1 bit: high while the FSM is in GRANT or GAP.

Function
REQ-011 Tick generator: counter 0..CLK_DIV-1; it shall emit a one-cycle tick when the count equals CLK_DIV-1, then wrap to 0.
REQ-012 FSM states: IDLE, GRANT, GAP; all outputs registered.
REQ-013 IDLE: when any iREQ bit is high, the block shall select the first set bit searching upward from rr_ptr with wrap 3->0; oGNT shall show it on the next cycle; state goes to GRANT; slot counter clears to 0.
REQ-014 GRANT: the slot counter shall increment on each tick and saturate at SLOT_TICKS.
REQ-015 GRANT: oLED shall equal iLED_REQ[owner] with one cycle of latency.
REQ-016 GRANT: when iREQ[owner] goes low, the FSM shall move to GAP on the next cycle, regardless of the slot count.
REQ-017 GRANT: when the slot count equals SLOT_TICKS and any non-owner iREQ is high, the FSM shall move to GAP on the next cycle (preemption).
REQ-018 GRANT: with a sole requester, the grant shall be held indefinitely.
REQ-019 If owner release and preemption occur in the same cycle, the result is one transition to GAP.
REQ-020 On leaving GRANT: rr_ptr <= (owner+1) mod 4.
REQ-021 GAP: oGNT=0 and oLED=0; the FSM shall go to IDLE on the cycle after the next tick. New requests are evaluated only in IDLE.
REQ-022 IDLE: oGNT=0; oLED=0, except as defined in REQ-026.
REQ-023 oGNT shall never have more than one bit set. Changes to iREQ bits of non-owners shall not affect oLED.

Reset
REQ-024 When iRST_N is low, the block shall immediately force: state=IDLE, oGNT=0, oLED=0, oBUSY=0, rr_ptr=0, tick counter=0, slot counter=0, heartbeat state=0. This applies mid-grant too.
REQ-025 After release of iRST_N, the first grant shall be possible on the first rising edge after release.

Configuration
REQ-026 With LED_ARB_IDLE_BLINK_EN defined, oLED in IDLE shall toggle every HB_TICKS ticks, and the heartbeat shall restart at 0 on each entry to IDLE. Without the macro, oLED in IDLE shall be 0 and no heartbeat logic shall exist.

Structure
REQ-027 Package led_arb_pkg shall hold: the state enum (IDLE/GRANT/GAP), NUM_REQ=4, and the default CLK_DIV, SLOT_TICKS and HB_TICKS constants.
REQ-028 Sub-module led_tick_gen shall contain the prescaler: CLK_DIV parameter, iCLK/iRST_N in, tick out. The counter width shall be $clog2(CLK_DIV).

Verification (CLK_DIV=4, SLOT_TICKS=3, HB_TICKS=2)
REQ-029 Reset with iREQ=1111 held, then release -> during reset oGNT=0000, oLED=0, oBUSY=0; after release the first grant is 0001.
REQ-030 iREQ=0001, iLED_REQ=0001 -> oGNT=0001 after 1 cycle and oLED=1 after 2 cycles; still granted after 20 ticks.
REQ-031 iREQ=1111 constant -> grant order 0001,0010,0100,1000,0001; each owner holds for >= 3 ticks; oLED=0 in every gap.
REQ-032 Owner 0 drops iREQ after 1 tick while iREQ[1]=1 -> oGNT=0000 next cycle; gap ends after the next tick; then oGNT=0010.
REQ-033 iRST_N pulsed low during GRANT of owner 2 -> outputs 0 within the same cycle; after release with iREQ=1111 the grant is 0001 (rr_ptr reset).
REQ-034 LED_ARB_IDLE_BLINK_EN defined, iREQ=0 -> oLED toggles every 8 cycles; with the macro undefined, oLED stays 0.
